mmm_redc_256b: RTL and testbench
================================

Name: mmm_redc_256b

Overview:
- Second step of the 256-bit Montgomery modular multiplication: the reduction side.
- Consumes the wide product T from the 3-way Karatsuba multiplier stage. Returns T·2^-256 mod N as a 256-bit residue.
- Word-serial Montgomery REDC, one WW-bit word per iteration, with a valid/ready handshake on both input and output.
- Sits between the multiplier output register and the next MMM operand feed.

Parameters:
- IDW, 522, width of the incoming product bus (only bits [2*DW-1:0] carry data).
- DW, 256, modulus/result width.
- WW, 64, reduction word width; DW must be a multiple of WW.
- NW, DW/WW (derived localparam, 4), number of reduction iterations.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  input request.
- o_ready  out  1  block can accept input.
- i_t  in  IDW  product T to reduce.
- i_n  in  DW  modulus N, odd.
- i_ninv  in  WW  n' = -N^-1 mod 2^WW.
- o_valid  out  1  result available.
- i_ready  in  1  downstream accepts result.
- o_res  out  DW  reduced result, in [0, N).
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (i_rst=1 at a rising edge):
  - state=IDLE; o_valid=0, o_res=0, o_busy=0, o_ready=1.
  - Internal acc, m, cnt and latched N/n' all cleared.
  - Reset mid-operation discards the operation; no partial result is ever emitted.
- o_ready = (state==IDLE). o_busy = !o_ready.
- Accept: on a rising edge with state==IDLE and i_valid=1:
  - Latch acc <= {1'b0, i_t[2*DW-1:0]} (acc width 2*DW+1); latch N and n'; cnt <= 0; go to MCALC.
  - i_t[IDW-1:2*DW] is ignored.
- While not IDLE, i_valid and i_t/i_n/i_ninv are ignored. No queueing.
- MCALC (1 cycle): m <= (acc[WW-1:0] * n') mod 2^WW → ACC.
- ACC (1 cycle):
  - acc <= (acc + m*N) >> WW. Low WW bits of the sum are zero by construction; the sum needs 2*DW+1 bits, no truncation.
  - cnt <= cnt+1.
  - If cnt==NW-1 → FINAL, else → MCALC.
- FINAL (1 cycle): o_res <= (acc >= N) ? acc-N : acc[DW-1:0]; o_valid <= 1 → DONE.
- DONE:
  - o_valid=1; o_res held stable until a rising edge with i_ready=1.
  - On that edge: o_valid <= 0, → IDLE. o_res retains its value afterwards.
  - If i_valid is also high on that same edge, it is NOT accepted; o_ready is 1 only from the following cycle.
- Latency: handshake edge to o_valid=1 is exactly 2*NW+2 cycles (10 for defaults). Throughput is one result per 2*NW+3 cycles minimum.
- Precondition: T < N·2^DW. This gives a pre-subtract acc < 2N, so one conditional subtract suffices. Out-of-range T yields an unspecified o_res but still exactly one o_valid pulse/handshake.
- i_ready high while o_valid=0 has no effect.

Optional Feature:
- Macro: MMM_REDC_RANGE_CHK_EN.
- Defined:
  - Adds output port o_err (1 bit, reset 0), registered alongside o_res in FINAL.
  - o_err=1 if any bit of i_t[IDW-1:2*DW] was set at accept, or if the pre-subtract acc >= 2N.
  - o_err has the same valid/hold timing as o_res and clears with o_valid.
- Undefined: no o_err port, no comparison logic. All other behaviour identical.

Test Plan:
- Reset idle: hold i_rst 3 cycles with i_valid=1 → o_ready=1, o_valid=0, o_res=0, o_busy=0; no accept while i_rst=1.
- Identity: N=2^256-189, n' computed by bench, T=0x1234<<256, i_ready=1 → o_valid exactly 10 cycles after the handshake edge, o_res=0x1234.
- Final subtract: same N, T=N → o_res=0 (pre-subtract acc==N). T=0 → o_res=0.
- Random: 1000 random T < N·2^256 against a golden model T·2^-256 mod N → all match; each o_valid is 10 cycles after its handshake.
- Backpressure: i_ready=0 for 5 cycles after o_valid → o_valid and o_res stable, o_ready=0, new i_valid ignored. i_ready=1 → o_ready=1 next cycle.
- Reset mid-op: assert i_rst at cycle 4 after accept → next cycle o_busy=0, o_ready=1, no o_valid pulse. A following operation returns the correct result.

Source files
------------

// File: rtl/mmm_redc_256b.sv
// mmm_redc_256b: word-serial Montgomery REDC, o_res = T*2^-DW mod N, valid/ready on both sides.
// Define MMM_REDC_RANGE_CHK_EN to add o_err, flagging a T outside [0, N*2^DW).
module mmm_redc_256b #(
  parameter int IDW = 522,
  parameter int DW  = 256,
  parameter int WW  = 64
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [IDW-1:0] i_t,
  input  logic [DW-1:0]  i_n,
  input  logic [WW-1:0]  i_ninv,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [DW-1:0]  o_res,
  output logic           o_busy
`ifdef MMM_REDC_RANGE_CHK_EN
  ,
  output logic           o_err
`endif
);
  localparam int NW = DW / WW;
  localparam int AW = 2 * DW + 1;
  localparam int CW = $clog2(NW + 1);
  typedef enum logic [2:0] {IDLE, MCALC, ACC, FINAL, DONE} state_t;
  state_t           state;
  logic [AW-1:0]    acc;
  logic [WW-1:0]    m;
  logic [WW-1:0]    ninv_r;
  logic [DW-1:0]    n_r;
  logic [CW-1:0]    cnt;
  logic [WW+DW-1:0] prod;
  logic [AW:0]      sum;
  logic             ge_n;
  assign o_ready = state == IDLE;
  assign o_busy  = !o_ready;
  assign prod    = {{DW{1'b0}}, m} * {{WW{1'b0}}, n_r};
  // m makes the low WW bits of sum zero, so the shift below drops nothing
  assign sum     = {1'b0, acc} + (AW+1)'(prod);
  assign ge_n    = acc >= AW'(n_r);
`ifdef MMM_REDC_RANGE_CHK_EN
  logic hi_err;
  logic ge_2n;
  assign ge_2n = acc >= AW'({n_r, 1'b0});
`else
  logic unused_hi;
  assign unused_hi = ^i_t[IDW-1:2*DW];
`endif
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      acc     <= '0;
      m       <= '0;
      ninv_r  <= '0;
      n_r     <= '0;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_res   <= '0;
`ifdef MMM_REDC_RANGE_CHK_EN
      hi_err  <= 1'b0;
      o_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          acc    <= AW'(i_t[2*DW-1:0]);
          n_r    <= i_n;
          ninv_r <= i_ninv;
          cnt    <= '0;
          state  <= MCALC;
`ifdef MMM_REDC_RANGE_CHK_EN
          hi_err <= |i_t[IDW-1:2*DW];
`endif
        end
        MCALC: begin
          m     <= acc[WW-1:0] * ninv_r;
          state <= ACC;
        end
        ACC: begin
          acc   <= AW'(sum >> WW);
          cnt   <= cnt + 1'b1;
          state <= (cnt == CW'(NW - 1)) ? FINAL : MCALC;
        end
        FINAL: begin
          o_res   <= ge_n ? acc[DW-1:0] - n_r : acc[DW-1:0];
          o_valid <= 1'b1;
          state   <= DONE;
`ifdef MMM_REDC_RANGE_CHK_EN
          o_err   <= hi_err | ge_2n;
`endif
        end
        DONE: if (i_ready) begin
          o_valid <= 1'b0;
          state   <= IDLE;
`ifdef MMM_REDC_RANGE_CHK_EN
          o_err   <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmm_redc_256b.sv
// tb_mmm_redc_256b: random and directed REDC operations checked against a modular-arithmetic model.
module tb_mmm_redc_256b;
  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b0;
  logic [521:0] i_t = '0;
  logic [255:0] i_n = '0;
  logic [63:0]  i_ninv = '0;
  logic         o_ready, o_valid, o_busy;
  logic [255:0] o_res;
`ifdef MMM_REDC_RANGE_CHK_EN
  logic         o_err;
`endif
  int checks = 0;
  int errors = 0;
  mmm_redc_256b dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_t(i_t), .i_n(i_n), .i_ninv(i_ninv), .o_valid(o_valid),
    .i_ready(i_ready), .o_res(o_res), .o_busy(o_busy)
`ifdef MMM_REDC_RANGE_CHK_EN
    , .o_err(o_err)
`endif
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  // T * 2^-256 mod N: 2^-256 built by repeated halving mod N, then plain wide multiply/modulo
  function automatic logic [255:0] redc_model(input logic [511:0] t, input logic [255:0] n);
    logic [511:0]  r = 512'd1;
    logic [1023:0] a;
    for (int i = 0; i < 256; i++) r = r[0] ? (r + {256'd0, n}) >> 1 : r >> 1;
    a = {512'd0, t} % {768'd0, n};
    a = (a * {512'd0, r}) % {768'd0, n};
    return a[255:0];
  endfunction
  function automatic logic [63:0] ninv_of(input logic [63:0] n0);
    logic [63:0] x = n0;
    for (int i = 0; i < 6; i++) x = x * (64'd2 - n0 * x);
    return -x;
  endfunction
  function automatic logic [255:0] rand256();
    logic [255:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction
  int           cyc = 0;
  logic         mon_en = 1'b0;
  logic         pend = 1'b0;
  logic         prev_v = 1'b0;
  int           acc_cyc = 0;
  logic [255:0] exp_res = '0;
  always @(posedge i_clk) cyc <= cyc + 1;
  always @(negedge i_clk) if (mon_en) begin
    chk("busy_vs_ready", {255'd0, o_busy}, {255'd0, !o_ready});
    if (o_valid && !prev_v) begin
      if (!pend) chk("spurious_valid", {255'd0, o_valid}, 256'd0);
      else begin
        chk("latency", 256'(cyc - acc_cyc + 1), 256'd10);
        chk("result", o_res, exp_res);
        pend = 1'b0;
      end
    end else if (o_valid) chk("held_result", o_res, exp_res);
    else if (pend && cyc - acc_cyc + 1 >= 10) begin
      chk("valid_missing", {255'd0, o_valid}, 256'd1);
      pend = 1'b0;
    end
    prev_v = o_valid;
    if (i_rst) pend = 1'b0;
    else if (i_valid && o_ready) begin
      pend    = 1'b1;
      acc_cyc = cyc + 1;
      exp_res = redc_model(i_t[511:0], i_n);
    end
  end
  task automatic send(input logic [521:0] t, input logic [255:0] n);
    int w = 0;
    while (o_ready !== 1'b1 && w < 40) begin @(posedge i_clk); #1; w++; end
    if (o_ready !== 1'b1) chk("ready_timeout", {255'd0, o_ready}, 256'd1);
    i_valid = 1'b1;
    i_t     = t;
    i_n     = n;
    i_ninv  = ninv_of(n[63:0]);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_t     = ~t;
    i_n     = ~n;
    i_ninv  = ~i_ninv;
  endtask
  task automatic finish_op(input int hold, output logic [255:0] r);
    int w = 0;
    while (o_valid !== 1'b1 && w < 40) begin @(posedge i_clk); #1; w++; end
    r = o_res;
    if (o_valid !== 1'b1) chk("valid_timeout", {255'd0, o_valid}, 256'd1);
    else begin
      if (hold > 0) begin
        i_ready = 1'b0;
        repeat (hold) begin @(posedge i_clk); #1; end
      end
      i_ready = 1'b1;
      @(posedge i_clk); #1;
    end
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [255:0] n0, n1, n, r, hi, lo;
    logic [63:0]  q;
    n0 = '1 - 256'd188;
    n1 = rand256() | {1'b1, 254'd0, 1'b1};
    chk("model_identity", redc_model({240'd0, 16'h1234, 256'd0}, n0), 256'h1234);
    chk("model_t_eq_n", redc_model({256'd0, n0}, n0), 256'd0);
    chk("model_r", redc_model({255'd0, 1'b1, 256'd0}, n0), 256'd1);
    q = ninv_of(n0[63:0]) * n0[63:0];
    chk("model_ninv", {192'd0, q}, {192'd0, 64'hFFFF_FFFF_FFFF_FFFF});
    i_valid = 1'b1;
    i_t = {10'h3ff, 512'h5};
    i_n = n0;
    repeat (3) begin
      @(posedge i_clk); #1;
      chk("rst_ready", {255'd0, o_ready}, 256'd1);
      chk("rst_valid", {255'd0, o_valid}, 256'd0);
      chk("rst_res", o_res, 256'd0);
      chk("rst_busy", {255'd0, o_busy}, 256'd0);
    end
    i_rst = 1'b0;
    i_valid = 1'b0;
    mon_en = 1'b1;
    @(posedge i_clk); #1;
    chk("idle_after_rst", {255'd0, o_ready}, 256'd1);
    i_ready = 1'b1;
    send({10'd0, 240'd0, 16'h1234, 256'd0}, n0);
    finish_op(0, r);
    chk("identity", r, 256'h1234);
    chk("res_retained", o_res, 256'h1234);
    send({266'd0, n0}, n0);
    finish_op(0, r);
    chk("t_eq_n", r, 256'd0);
    send(522'd0, n0);
    finish_op(0, r);
    chk("t_zero", r, 256'd0);
    send({10'd0, n0 - 256'd1, '1}, n0);
    finish_op(1, r);
    chk("t_max", r, redc_model({n0 - 256'd1, 256'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF}, n0));
    i_ready = 1'b0;
    send({10'd0, 240'd0, 16'h00ab, 256'd0}, n0);
    r = '0;
    for (int w = 0; w < 40 && o_valid !== 1'b1; w++) begin @(posedge i_clk); #1; end
    chk("bp_first", o_res, 256'hab);
    repeat (5) begin
      i_valid = 1'b1;
      i_t = {10'd0, rand256(), rand256()};
      @(posedge i_clk); #1;
      chk("bp_valid", {255'd0, o_valid}, 256'd1);
      chk("bp_res", o_res, 256'hab);
      chk("bp_ready", {255'd0, o_ready}, 256'd0);
    end
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    chk("bp_release_ready", {255'd0, o_ready}, 256'd1);
    chk("bp_release_valid", {255'd0, o_valid}, 256'd0);
    chk("bp_release_res", o_res, 256'hab);
    repeat (15) @(posedge i_clk);
    #1;
    send({10'd0, rand256() % n1, rand256()}, n1);
    repeat (3) begin @(posedge i_clk); #1; end
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("midrst_busy", {255'd0, o_busy}, 256'd0);
    chk("midrst_ready", {255'd0, o_ready}, 256'd1);
    chk("midrst_valid", {255'd0, o_valid}, 256'd0);
    chk("midrst_res", o_res, 256'd0);
    repeat (15) @(posedge i_clk);
    #1;
    send({10'd0, 240'd0, 16'h7777, 256'd0}, n1);
    finish_op(0, r);
    chk("after_midrst", r, 256'h7777);
    for (int k = 0; k < 1000; k++) begin
      n  = $urandom_range(0, 1) ? n0 : n1;
      hi = rand256() % n;
      lo = rand256();
      if (k % 97 == 0) begin hi = n - 256'd1; lo = '1; end
      if (k % 89 == 0) hi = '0;
      send({10'd0, hi, lo}, n);
      finish_op($urandom_range(0, 2), r);
    end
    repeat (12) @(posedge i_clk);
    #1;
    chk("nothing_pending", {255'd0, pend}, 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
